// File: rtl/addsub_serial.sv
// rtl/addsub_serial.sv - chunk-serial adder/subtractor with valid/ready handshake
//
// Adds or subtracts two WIDTH-bit operands CHUNK bits per clock, LSB slice first.
// An operation takes N = WIDTH/CHUNK clock edges after it is accepted.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   operands/mode present
//   in_ready   block can accept operands (IDLE only)
//   in1, in2   operands A and B
//   sub        0 = A+B, 1 = A-B
//   out_valid  result and flags valid (DONE only)
//   out_ready  consumer takes result
//   out_data   result, modulo 2^WIDTH
//   carry      carry out of MSB (for subtract: 1 = no borrow)
//   overflow   two's-complement signed overflow
//   zero       out_data == 0
//   negative   out_data[WIDTH-1]
module addsub_serial #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             carry,
  output logic             overflow,
  output logic             zero,
  output logic             negative
);

  localparam int N     = WIDTH / CHUNK;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_q;    // operand A, progressively replaced by the sum
  logic [WIDTH-1:0] b_q;    // operand B (inverted for subtract), shifted down
  logic [IDX_W-1:0] idx;
  logic             cy;

  logic [CHUNK:0]   slice_sum;
  logic [WIDTH-1:0] a_rot;
  logic             msb_cin;
  logic             last;

  // The current slice always sits in the low CHUNK bits. The slice sum is
  // rotated in at the top of a_q so that after N steps a_q holds the result.
  always_comb begin
    slice_sum = {1'b0, a_q[CHUNK-1:0]} + {1'b0, b_q[CHUNK-1:0]} + {{CHUNK{1'b0}}, cy};
    // Carry into the MSB recovered from the MSB sum bit: s = a ^ b ^ cin.
    msb_cin   = a_q[CHUNK-1] ^ b_q[CHUNK-1] ^ slice_sum[CHUNK-1];
    last      = (idx == IDX_W'(N - 1));
  end

  generate
    if (N == 1) begin : g_single
      assign a_rot = slice_sum[CHUNK-1:0];
    end else begin : g_multi
      assign a_rot = {slice_sum[CHUNK-1:0], a_q[WIDTH-1:CHUNK]};
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      idx       <= '0;
      cy        <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_data  <= '0;
      carry     <= 1'b0;
      overflow  <= 1'b0;
      zero      <= 1'b0;
      negative  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_q      <= in1;
            b_q      <= sub ? ~in2 : in2;
            cy       <= sub;
            idx      <= '0;
            in_ready <= 1'b0;
            state    <= CALC;
          end
        end
        CALC: begin
          a_q <= a_rot;
          b_q <= b_q >> CHUNK;
          cy  <= slice_sum[CHUNK];
          if (last) begin
            out_data  <= a_rot;
            carry     <= slice_sum[CHUNK];
            overflow  <= msb_cin ^ slice_sum[CHUNK];
            zero      <= (a_rot == '0);
            negative  <= a_rot[WIDTH-1];
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            idx <= idx + IDX_W'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_addsub_serial.sv
// tb/tb_addsub_serial.sv - self-checking bench for addsub_serial
module tb_addsub_serial;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;

  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in1 = '0;
  logic [31:0] in2 = '0;
  logic        sub = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;
  logic        carry, overflow, zero, negative;

  logic        in_valid16 = 1'b0;
  logic        in_ready16;
  logic [15:0] in1_16 = '0;
  logic [15:0] in2_16 = '0;
  logic        sub16 = 1'b0;
  logic        out_valid16;
  logic        out_ready16 = 1'b0;
  logic [15:0] out_data16;
  logic        carry16, overflow16, zero16, negative16;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  addsub_serial #(.WIDTH(32), .CHUNK(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in1(in1), .in2(in2), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .carry(carry), .overflow(overflow),
    .zero(zero), .negative(negative)
  );

  addsub_serial #(.WIDTH(16), .CHUNK(16)) dut16 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid16), .in_ready(in_ready16),
    .in1(in1_16), .in2(in2_16), .sub(sub16),
    .out_valid(out_valid16), .out_ready(out_ready16),
    .out_data(out_data16), .carry(carry16), .overflow(overflow16),
    .zero(zero16), .negative(negative16)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain unsigned/signed arithmetic on w-bit operands.
  task automatic model(input int w, input logic [63:0] a, input logic [63:0] b, input logic s,
                       output logic [63:0] r, output logic c, output logic v,
                       output logic z, output logic n);
    longint sa, sb, sr, lim;
    logic [63:0] mask;
    mask = (64'd1 << w) - 64'd1;
    r    = (s ? a - b : a + b) & mask;
    c    = s ? (a >= b) : (((a + b) >> w) != 64'd0);
    lim  = longint'(1) << (w - 1);
    sa   = a[w-1] ? longint'(a) - (lim * 2) : longint'(a);
    sb   = b[w-1] ? longint'(b) - (lim * 2) : longint'(b);
    sr   = s ? sa - sb : sa + sb;
    v    = (sr > lim - 1) || (sr < -lim);
    z    = (r == 64'd0);
    n    = r[w-1];
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_out(input int exp_lat);
    int lat;
    lat = 0;
    while (!out_valid && lat < 50) begin
      step();
      lat++;
    end
    chk("latency", 64'(lat), 64'(exp_lat));
  endtask

  task automatic chk_result(input string tag, input logic [31:0] a, input logic [31:0] b, input logic s);
    logic [63:0] r;
    logic c, v, z, n;
    model(32, {32'd0, a}, {32'd0, b}, s, r, c, v, z, n);
    chk({tag, "_valid"}, 64'(out_valid), 64'd1);
    chk({tag, "_data"},  64'(out_data), r);
    chk({tag, "_carry"}, 64'(carry), 64'(c));
    chk({tag, "_ovf"},   64'(overflow), 64'(v));
    chk({tag, "_zero"},  64'(zero), 64'(z));
    chk({tag, "_neg"},   64'(negative), 64'(n));
  endtask

  // One full transaction on the 32-bit instance with hold cycles of back-pressure.
  task automatic do_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                       input logic s, input int hold);
    int t;
    t = 0;
    while (!in_ready && t < 50) begin
      step();
      t++;
    end
    chk({tag, "_in_ready"}, 64'(in_ready), 64'd1);
    in1 = a; in2 = b; sub = s; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    in1 = $urandom; in2 = $urandom; sub = 1'($urandom);
    wait_out(4);
    chk_result(tag, a, b, s);
    for (int i = 0; i < hold; i++) begin
      step();
      chk({tag, "_hold_valid"}, 64'(out_valid), 64'd1);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk({tag, "_release"}, 64'(out_valid), 64'd0);
  endtask

  initial begin
    logic [63:0] r;
    logic        c, v, z, n;
    logic [31:0] ra, rb;
    logic        rs;
    int          lat;

    // Reset state
    #2 rst_n = 1'b0;
    #10;
    chk("rst_in_ready",  64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data",  64'(out_data), 64'd0);
    chk("rst_flags",     64'({carry, overflow, zero, negative}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // Directed corner cases
    do_op("add_wrap", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 0);
    chk("add_wrap_data_const", 64'(out_data), 64'h0);
    do_op("sub_ovf",  32'h8000_0000, 32'h0000_0001, 1'b1, 1);
    chk("sub_ovf_data_const", 64'(out_data), 64'h7FFF_FFFF);
    do_op("sub_borrow", 32'h0000_0005, 32'h0000_0007, 1'b1, 0);
    chk("sub_borrow_data_const", 64'(out_data), 64'hFFFF_FFFE);

    // Back-pressure with in_valid held high and new operands on the bus
    in1 = 32'h0102_0304; in2 = 32'hF0F0_F0F0; sub = 1'b0; in_valid = 1'b1;
    step();
    in1 = 32'h7000_0000; in2 = 32'h1000_0000; sub = 1'b0;
    wait_out(4);
    chk_result("bp_first", 32'h0102_0304, 32'hF0F0_F0F0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("bp_in_ready", 64'(in_ready), 64'd0);
      chk_result("bp_hold", 32'h0102_0304, 32'hF0F0_F0F0, 1'b0);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("bp_idle_valid", 64'(out_valid), 64'd0);
    chk("bp_idle_ready", 64'(in_ready), 64'd1);
    step();
    in_valid = 1'b0;
    wait_out(4);
    chk_result("bp_second", 32'h7000_0000, 32'h1000_0000, 1'b0);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;

    // Reset mid-calculation
    in1 = 32'h1234_5678; in2 = 32'h1111_1111; sub = 1'b0; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    step();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_data",  64'(out_data), 64'd0);
    chk("mid_rst_flags", 64'({carry, overflow, zero, negative}), 64'd0);
    chk("mid_rst_ready", 64'(in_ready), 64'd1);
    step();
    rst_n = 1'b1;
    step();
    chk("post_rst_ready", 64'(in_ready), 64'd1);
    chk("post_rst_valid", 64'(out_valid), 64'd0);
    do_op("post_rst_add", 32'h0000_0001, 32'h0000_0002, 1'b0, 0);
    chk("post_rst_data_const", 64'(out_data), 64'h3);

    // Randomized operations
    for (int k = 0; k < 20; k++) begin
      ra = $urandom;
      rb = (k % 5 == 0) ? ra : 32'($urandom);
      rs = 1'($urandom);
      do_op("rand", ra, rb, rs, int'($urandom_range(0, 2)));
    end

    // Single-chunk instance: latency of one edge
    for (int k = 0; k < 6; k++) begin
      if (k == 0) begin
        in1_16 = 16'h7FFF; in2_16 = 16'h0001; sub16 = 1'b0;
      end else begin
        in1_16 = 16'($urandom); in2_16 = 16'($urandom); sub16 = 1'($urandom);
      end
      chk("w16_in_ready", 64'(in_ready16), 64'd1);
      in_valid16 = 1'b1;
      step();
      in_valid16 = 1'b0;
      lat = 0;
      while (!out_valid16 && lat < 50) begin
        step();
        lat++;
      end
      chk("w16_latency", 64'(lat), 64'd1);
      model(16, {48'd0, in1_16}, {48'd0, in2_16}, sub16, r, c, v, z, n);
      if (k == 0) chk("w16_data_const", 64'(out_data16), 64'h8000);
      chk("w16_data",  64'(out_data16), r);
      chk("w16_carry", 64'(carry16), 64'(c));
      chk("w16_ovf",   64'(overflow16), 64'(v));
      chk("w16_zero",  64'(zero16), 64'(z));
      chk("w16_neg",   64'(negative16), 64'(n));
      out_ready16 = 1'b1;
      step();
      out_ready16 = 1'b0;
      chk("w16_release", 64'(out_valid16), 64'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
